// File: rtl/noc_fifo_pkg.sv
// Shared definitions for the NoC virtual-channel input buffer.
// Holds the count-width helper, read-mode constants and the VC index type.
package noc_fifo_pkg;

    localparam int FIFO_MODE_REG  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // VC indices are widened to this type before range checks against NUM_VC.
    localparam int VC_ID_W = 8;
    typedef logic [VC_ID_W-1:0] vc_id_t;

    // Occupancy needs one extra bit so a full FIFO (count == DEPTH) is representable.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/vc_fifo_chan.sv
// One virtual channel: storage, wrap-bit pointers and derived status.
// push/pop arrive already qualified by the top level.
module vc_fifo_chan
    import noc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = DEPTH - 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_WIDTH-1:0]      din,
    input  logic                       pop,
    output logic [DATA_WIDTH-1:0]      head,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_full,
    output logic [cnt_w(DEPTH)-1:0]    count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]         wr_ptr;
    logic [CW-1:0]         rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end

    // Wrap bit distinguishes full (MSBs differ) from empty (pointers equal).
    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count       = wr_ptr - rd_ptr;
    assign almost_full = (count >= CW'(AF_THRESH));
    assign head        = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/vc_fifo.sv
// Multi-VC input buffer: shared write/read ports over NUM_VC channel FIFOs,
// with registered or fall-through read data, credit return and sticky error flags.
module vc_fifo
    import noc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int NUM_VC     = 4,
    parameter int VC_W       = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int FWFT       = FIFO_MODE_REG
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wr_en,
    input  logic [VC_W-1:0]                   wr_vc,
    input  logic [DATA_WIDTH-1:0]             din,
    input  logic                              rd_en,
    input  logic [VC_W-1:0]                   rd_vc,
    output logic [DATA_WIDTH-1:0]             dout,
    output logic                              dout_valid,
    output logic [NUM_VC-1:0]                 empty,
    output logic [NUM_VC-1:0]                 full,
    output logic [NUM_VC-1:0]                 almost_full,
    output logic [NUM_VC*cnt_w(DEPTH)-1:0]    count,
    output logic [NUM_VC-1:0]                 credit_out,
    output logic [NUM_VC-1:0]                 overflow,
    output logic [NUM_VC-1:0]                 underflow
);

    localparam int CW = cnt_w(DEPTH);

    logic                  wr_vc_ok;
    logic                  rd_vc_ok;
    logic [NUM_VC-1:0]     wr_sel;
    logic [NUM_VC-1:0]     rd_sel;
    logic [NUM_VC-1:0]     push;
    logic [NUM_VC-1:0]     pop;
    logic [DATA_WIDTH-1:0] heads [NUM_VC];
    logic [DATA_WIDTH-1:0] head_sel;
    logic                  empty_sel;
    logic                  rd_accept;
    logic [DATA_WIDTH-1:0] dout_p0;
    logic                  vld_p0;
    logic                  fwft_valid;
    logic [DATA_WIDTH-1:0] fwft_dout;

    // Out-of-range VC ids address nothing and raise no flag.
    assign wr_vc_ok = (vc_id_t'(wr_vc) < vc_id_t'(NUM_VC));
    assign rd_vc_ok = (vc_id_t'(rd_vc) < vc_id_t'(NUM_VC));

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        assign wr_sel[v] = wr_en && wr_vc_ok && (vc_id_t'(wr_vc) == vc_id_t'(v));
        assign rd_sel[v] = rd_en && rd_vc_ok && (vc_id_t'(rd_vc) == vc_id_t'(v));
        assign push[v]   = wr_sel[v] && !full[v];
        assign pop[v]    = rd_sel[v] && !empty[v];

        vc_fifo_chan #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH),
            .AF_THRESH  (AF_THRESH)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .push        (push[v]),
            .din         (din),
            .pop         (pop[v]),
            .head        (heads[v]),
            .empty       (empty[v]),
            .full        (full[v]),
            .almost_full (almost_full[v]),
            .count       (count[v*CW +: CW])
        );
    end

    always_comb begin
        head_sel  = '0;
        empty_sel = 1'b1;
        for (int v = 0; v < NUM_VC; v++) begin
            if (vc_id_t'(rd_vc) == vc_id_t'(v)) begin
                head_sel  = heads[v];
                empty_sel = empty[v];
            end
        end
    end

    assign rd_accept = |pop;

    // Stage p0: registered read data, credit pulses and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_p0    <= '0;
            vld_p0     <= 1'b0;
            credit_out <= '0;
            overflow   <= '0;
            underflow  <= '0;
        end else begin
            vld_p0     <= rd_accept;
            if (rd_accept) dout_p0 <= head_sel;
            credit_out <= pop;
            overflow   <= overflow | (wr_sel & full);
            underflow  <= underflow | (rd_sel & empty);
        end
    end

    // Fall-through output is masked to zero while nothing is displayable.
    assign fwft_valid = rd_vc_ok && !empty_sel;
    assign fwft_dout  = fwft_valid ? head_sel : '0;

    assign dout       = (FWFT == FIFO_MODE_FWFT) ? fwft_dout  : dout_p0;
    assign dout_valid = (FWFT == FIFO_MODE_FWFT) ? fwft_valid : vld_p0;

endmodule

// File: tb/tb_vc_fifo.sv
// Self-checking bench for vc_fifo: registered-read and FWFT instances share stimulus,
// expectations come from per-VC queues.
module tb_vc_fifo;

    localparam int DW = 32;
    localparam int DEPTH = 16;
    localparam int NV = 4;
    localparam int CW = 5;
    localparam int AF = 14;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [1:0]    wr_vc = '0;
    logic [1:0]    rd_vc = '0;
    logic [DW-1:0] din = '0;

    logic [DW-1:0]    dout, dout_f;
    logic             dv, dv_f;
    logic [NV-1:0]    empty, full, af, credit, ovf, unf;
    logic [NV-1:0]    empty_f, full_f, af_f, credit_f, ovf_f, unf_f;
    logic [NV*CW-1:0] count, count_f;

    int nvec = 0;
    int nerr = 0;

    logic [DW-1:0] q [NV][$];
    logic [DW-1:0] exp_dout;
    logic          exp_dv;
    logic [NV-1:0] exp_credit, exp_ovf, exp_unf;

    always #5 clk = ~clk;

    vc_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_VC(NV), .VC_W(2), .AF_THRESH(AF), .FWFT(0)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_vc(wr_vc), .din(din), .rd_en(rd_en), .rd_vc(rd_vc),
        .dout(dout), .dout_valid(dv), .empty(empty), .full(full), .almost_full(af), .count(count),
        .credit_out(credit), .overflow(ovf), .underflow(unf));

    vc_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_VC(NV), .VC_W(2), .AF_THRESH(AF), .FWFT(1)) dut_f (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_vc(wr_vc), .din(din), .rd_en(rd_en), .rd_vc(rd_vc),
        .dout(dout_f), .dout_valid(dv_f), .empty(empty_f), .full(full_f), .almost_full(af_f), .count(count_f),
        .credit_out(credit_f), .overflow(ovf_f), .underflow(unf_f));

    function automatic int cnt_of(input int v);
        return int'(count[v*CW +: CW]);
    endfunction

    task automatic model_reset();
        for (int v = 0; v < NV; v++) q[v].delete();
        exp_dout = '0; exp_dv = 1'b0; exp_credit = '0; exp_ovf = '0; exp_unf = '0;
    endtask

    // Reads see the pre-edge occupancy, so a full VC pops but drops the write.
    task automatic model_step();
        bit wa, ra;
        wa = wr_en && (q[wr_vc].size() < DEPTH);
        ra = rd_en && (q[rd_vc].size() > 0);
        if (wr_en && !wa) exp_ovf[wr_vc] = 1'b1;
        if (rd_en && !ra) exp_unf[rd_vc] = 1'b1;
        exp_credit = '0;
        exp_dv = ra;
        if (ra) begin
            exp_credit[rd_vc] = 1'b1;
            exp_dout = q[rd_vc].pop_front();
        end
        if (wa) q[wr_vc].push_back(din);
    endtask

    task automatic apply(input bit we, input int wv, input logic [DW-1:0] d, input bit re, input int rv);
        wr_en = we; wr_vc = 2'(wv); din = d; rd_en = re; rd_vc = 2'(rv);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        nvec++; if (empty !== 4'hF) begin nerr++; $display("FAIL reset_empty got=%b exp=1111", empty); end
        nvec++; if ({full, af, credit, ovf, unf} !== 20'h0) begin nerr++; $display("FAIL reset_flags got=%h exp=0", {full, af, credit, ovf, unf}); end
        nvec++; if (count !== '0) begin nerr++; $display("FAIL reset_count got=%h exp=0", count); end
        nvec++; if (dout !== '0 || dv !== 1'b0) begin nerr++; $display("FAIL reset_dout got=%h/%b exp=0/0", dout, dv); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_fill_vc2();
        for (int i = 0; i < DEPTH; i++) begin
            apply(1, 2, DW'(32'hA0 + i), 0, 0);
            nvec++; if (cnt_of(2) !== i + 1) begin nerr++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, cnt_of(2), i + 1); end
            nvec++; if (af[2] !== (i + 1 >= AF)) begin nerr++; $display("FAIL fill_af i=%0d got=%b", i, af[2]); end
        end
        nvec++; if (full !== 4'b0100) begin nerr++; $display("FAIL fill_full got=%b exp=0100", full); end
        apply(1, 2, 32'hEE, 0, 0);
        nvec++; if (ovf !== 4'b0100) begin nerr++; $display("FAIL fill_overflow got=%b exp=0100", ovf); end
        nvec++; if (cnt_of(2) !== DEPTH) begin nerr++; $display("FAIL fill_count17 got=%0d exp=16", cnt_of(2)); end
    endtask

    task automatic test_pop_vc2();
        for (int i = 0; i < DEPTH; i++) begin
            apply(0, 0, '0, 1, 2);
            nvec++; if (dout !== DW'(32'hA0 + i) || dv !== 1'b1) begin nerr++; $display("FAIL pop_dout i=%0d got=%h/%b exp=%h/1", i, dout, dv, 32'hA0 + i); end
            nvec++; if (credit !== 4'b0100) begin nerr++; $display("FAIL pop_credit i=%0d got=%b exp=0100", i, credit); end
        end
        apply(0, 0, '0, 0, 0);
        nvec++; if (dv !== 1'b0 || credit !== 4'b0000) begin nerr++; $display("FAIL pop_idle got=%b/%b exp=0/0000", dv, credit); end
        nvec++; if (empty[2] !== 1'b1 || dout !== 32'hAF) begin nerr++; $display("FAIL pop_hold got=%b/%h exp=1/af", empty[2], dout); end
        apply(0, 0, '0, 1, 2);
        nvec++; if (unf !== 4'b0100 || dv !== 1'b0) begin nerr++; $display("FAIL pop_underflow got=%b/%b exp=0100/0", unf, dv); end
    endtask

    task automatic test_interleave();
        apply(1, 3, 32'h33, 0, 0);
        apply(1, 0, 32'h11, 1, 3);
        nvec++; if (dout !== 32'h33 || dv !== 1'b1) begin nerr++; $display("FAIL il_dout got=%h/%b exp=33/1", dout, dv); end
        nvec++; if (cnt_of(0) !== 1 || cnt_of(3) !== 0) begin nerr++; $display("FAIL il_count got=%0d/%0d exp=1/0", cnt_of(0), cnt_of(3)); end
        apply(0, 0, '0, 1, 0);
        nvec++; if (dout !== 32'h11 || credit !== 4'b0001) begin nerr++; $display("FAIL il_drain got=%h/%b exp=11/0001", dout, credit); end
    endtask

    task automatic test_same_vc_random();
        logic [DW-1:0] first;
        first = DW'($urandom);
        apply(1, 1, first, 0, 0);
        for (int i = 1; i < 5; i++) apply(1, 1, DW'($urandom), 0, 0);
        apply(1, 1, DW'($urandom), 1, 1);
        nvec++; if (cnt_of(1) !== 5) begin nerr++; $display("FAIL rw5_count got=%0d exp=5", cnt_of(1)); end
        nvec++; if (dout !== first) begin nerr++; $display("FAIL rw5_order got=%h exp=%h", dout, first); end
        for (int c = 0; c < 300; c++) begin
            int wv, rv;
            wv = ($urandom_range(0, 1) == 1) ? 1 : int'($urandom_range(0, 3));
            rv = ($urandom_range(0, 1) == 1) ? 1 : int'($urandom_range(0, 3));
            apply($urandom_range(0, 9) < 7, wv, DW'($urandom), $urandom_range(0, 9) < 6, rv);
            nvec++; if (dout !== exp_dout || dv !== exp_dv) begin nerr++; $display("FAIL rnd_dout c=%0d got=%h/%b exp=%h/%b", c, dout, dv, exp_dout, exp_dv); end
            nvec++; if (credit !== exp_credit || ovf !== exp_ovf || unf !== exp_unf) begin nerr++; $display("FAIL rnd_flags c=%0d got=%b/%b/%b exp=%b/%b/%b", c, credit, ovf, unf, exp_credit, exp_ovf, exp_unf); end
            for (int v = 0; v < NV; v++) begin
                nvec++;
                if (cnt_of(v) !== q[v].size() || empty[v] !== (q[v].size() == 0) ||
                    full[v] !== (q[v].size() == DEPTH) || af[v] !== (q[v].size() >= AF)) begin
                    nerr++; $display("FAIL rnd_status c=%0d vc=%0d cnt=%0d e/f/af=%b%b%b exp_cnt=%0d", c, v, cnt_of(v), empty[v], full[v], af[v], q[v].size());
                end
            end
            nvec++;
            if (dv_f !== (q[rd_vc].size() > 0) || dout_f !== ((q[rd_vc].size() > 0) ? q[rd_vc][0] : '0)) begin
                nerr++; $display("FAIL rnd_fwft c=%0d got=%h/%b", c, dout_f, dv_f);
            end
        end
    endtask

    task automatic test_fwft();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        apply(0, 0, '0, 0, 1);
        nvec++; if (dv_f !== 1'b0 || dout_f !== '0) begin nerr++; $display("FAIL fwft_empty got=%h/%b exp=0/0", dout_f, dv_f); end
        apply(1, 1, 32'h55, 0, 1);
        nvec++; if (dv_f !== 1'b1 || dout_f !== 32'h55) begin nerr++; $display("FAIL fwft_show got=%h/%b exp=55/1", dout_f, dv_f); end
        apply(0, 0, '0, 1, 1);
        nvec++; if (dv_f !== 1'b0) begin nerr++; $display("FAIL fwft_pop got=%b exp=0", dv_f); end
        nvec++; if (credit_f !== 4'b0010 || dout !== 32'h55) begin nerr++; $display("FAIL fwft_credit got=%b/%h exp=0010/55", credit_f, dout); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++) apply(1, 0, DW'($urandom), 0, 0);
        apply(0, 0, '0, 1, 0);
        nvec++; if (cnt_of(0) !== 6 || dv !== 1'b1) begin nerr++; $display("FAIL mid_pre got=%0d/%b exp=6/1", cnt_of(0), dv); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        nvec++; if (empty !== 4'hF || count !== '0) begin nerr++; $display("FAIL mid_async got=%b/%h exp=1111/0", empty, count); end
        nvec++; if (dv !== 1'b0 || dv_f !== 1'b0) begin nerr++; $display("FAIL mid_valid got=%b/%b exp=0/0", dv, dv_f); end
        @(posedge clk);
        #1;
        nvec++; if (credit !== '0 || credit_f !== '0) begin nerr++; $display("FAIL mid_credit got=%b/%b exp=0/0", credit, credit_f); end
        @(negedge clk);
        rd_en = 1'b0;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        test_reset();
        test_fill_vc2();
        test_pop_vc2();
        test_interleave();
        test_same_vc_random();
        test_fwft();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
